vga_timing_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 VGA controller.
- Generates hsync, vsync, data-enable and pixel coordinates for any CVT/DMT-style mode.
- Adds a pixel clock-enable, programmable sync polarity, fully registered and aligned outputs, and line/frame strobes.
- Sits between the system clock domain and the pixel pipeline (frame buffer reader / pattern generator), which consumes h_cnt, v_cnt and valid.

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/vga_axis_counter.sv | 40 ++++
 rtl/vga_timing_gen.sv | 115 +++++++++++
 tb/tb_vga_timing_gen.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Mode constants and sizing helper for the parametrised VGA timing generator.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    bit          h_pol;
    bit          v_pol;
  } vga_mode_t;

  localparam vga_mode_t MODE_640X480_60  = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam vga_mode_t MODE_800X600_60  = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
  localparam vga_mode_t MODE_1024X768_60 = '{1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0};

  // Smallest counter width that can hold max(HT,VT)-1.
  function automatic int unsigned min_cnt_w(input vga_mode_t m);
    int unsigned ht;
    int unsigned vt;
    int unsigned tmax;
    int unsigned w;
    ht   = m.h_active + m.h_fp + m.h_sync + m.h_bp;
    vt   = m.v_active + m.v_fp + m.v_sync + m.v_bp;
    tmax = (ht > vt) ? ht : vt;
    w    = 1;
    while ((32'd1 << w) < tmax) w++;
    return w;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one display axis, with active and sync window decode.
module vga_axis_counter #(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter int unsigned CNT_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_adv,
  output logic [CNT_W-1:0] o_pos,
  output logic             o_wrap,
  output logic             o_act,
  output logic             o_sync_act
);

  localparam logic [31:0] TOTAL   = 32'(ACTIVE + FP + SYNC + BP);
  localparam logic [31:0] ACT_END = 32'(ACTIVE);
  localparam logic [31:0] SYNC_LO = 32'(ACTIVE + FP);
  localparam logic [31:0] SYNC_HI = 32'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] r_pos;
  logic [31:0]      w_pos;

  assign w_pos      = 32'(r_pos);
  assign o_pos      = r_pos;
  assign o_wrap     = (w_pos == TOTAL - 32'd1);
  assign o_act      = (w_pos < ACT_END);
  assign o_sync_act = (w_pos >= SYNC_LO) && (w_pos < SYNC_HI);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos <= '0;
    end else if (i_adv) begin
      r_pos <= o_wrap ? '0 : r_pos + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/CVT timing generator with pixel enable and registered, aligned outputs.
// Optional macro VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = MODE_640X480_60.h_active,
  parameter int unsigned H_FP     = MODE_640X480_60.h_fp,
  parameter int unsigned H_SYNC   = MODE_640X480_60.h_sync,
  parameter int unsigned H_BP     = MODE_640X480_60.h_bp,
  parameter int unsigned V_ACTIVE = MODE_640X480_60.v_active,
  parameter int unsigned V_FP     = MODE_640X480_60.v_fp,
  parameter int unsigned V_SYNC   = MODE_640X480_60.v_sync,
  parameter int unsigned V_BP     = MODE_640X480_60.v_bp,
  parameter bit          H_POL    = MODE_640X480_60.h_pol,
  parameter bit          V_POL    = MODE_640X480_60.v_pol,
  parameter int unsigned CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic [15:0]      frame_cnt,
`endif
  output logic             hsync,
  output logic             vsync,
  output logic             valid,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             line_start,
  output logic             frame_start
);

  localparam longint unsigned HT    = longint'(H_ACTIVE) + H_FP + H_SYNC + H_BP;
  localparam longint unsigned VT    = longint'(V_ACTIVE) + V_FP + V_SYNC + V_BP;
  localparam longint unsigned CAPAC = longint'(1) << CNT_W;

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 || CNT_W == 0) begin : g_err_zero
    $error("vga_timing_gen: timing/width parameters must be non-zero");
  end
  if (HT > CAPAC || VT > CAPAC) begin : g_err_cnt_w
    $error("vga_timing_gen: CNT_W too small for HT/VT");
  end

  logic [CNT_W-1:0] w_hpos, w_vpos;
  logic             w_h_wrap, w_v_wrap_unused;
  logic             w_h_act, w_v_act, w_hs_act, w_vs_act;
  logic             w_valid, w_line_first, w_frame_first;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_W(CNT_W)
  ) u_h (
    .clk(clk), .rst(rst), .i_adv(ce),
    .o_pos(w_hpos), .o_wrap(w_h_wrap), .o_act(w_h_act), .o_sync_act(w_hs_act)
  );

  // Vertical axis steps once per line, so vsync changes only at the hpos=0 boundary.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_W(CNT_W)
  ) u_v (
    .clk(clk), .rst(rst), .i_adv(ce & w_h_wrap),
    .o_pos(w_vpos), .o_wrap(w_v_wrap_unused), .o_act(w_v_act), .o_sync_act(w_vs_act)
  );

  assign w_valid       = w_h_act & w_v_act;
  assign w_line_first  = (w_hpos == '0);
  assign w_frame_first = w_line_first & (w_vpos == '0);

  // Output stage: every output describes the same (hpos,vpos), one enabled cycle late.
  logic             r_hsync, r_vsync, r_valid, r_line_start, r_frame_start;
  logic [CNT_W-1:0] r_h_cnt, r_v_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_valid       <= 1'b0;
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (ce) begin
      r_hsync       <= w_hs_act ? H_POL : ~H_POL;
      r_vsync       <= w_vs_act ? V_POL : ~V_POL;
      r_valid       <= w_valid;
      r_h_cnt       <= w_valid ? w_hpos : '0;
      r_v_cnt       <= w_valid ? w_vpos : '0;
      r_line_start  <= w_line_first;
      r_frame_start <= w_frame_first;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign valid       = r_valid;
  assign h_cnt       = r_h_cnt;
  assign v_cnt       = r_v_cnt;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (ce && w_frame_first) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced 15x9 mode to keep frames short.
module tb_vga_timing_gen;

  localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int unsigned VA = 5, VF = 1, VS = 2, VB = 1;
  localparam int unsigned CW = 4;
  localparam bit          HP = 1'b0, VP = 1'b1;
  localparam int          HT = 15, VT = 9;
`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce  = 1'b0;
  logic          hsync, vsync, valid, line_start, frame_start;
  logic [CW-1:0] h_cnt, v_cnt;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(HP), .V_POL(VP), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ce(ce),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .hsync(hsync),
    .vsync(vsync),
    .valid(valid),
    .h_cnt(h_cnt),
    .v_cnt(v_cnt),
    .line_start(line_start),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          hp = 0;
  int          vp = 0;
  logic [15:0] m_fc = '0;
  logic [31:0] last_exp = '0;
  logic [31:0] q[$];

  function automatic logic [31:0] pack_obs();
    logic [15:0] fc;
    fc = '0;
`ifdef VGA_TIMING_FRAME_CNT_EN
    fc = frame_cnt;
`endif
    return {fc, hsync, vsync, valid, h_cnt, v_cnt, line_start, frame_start, 3'b000};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one clock with the given ce/rst, push the expected outputs, then compare.
  task automatic step(input bit c, input bit r, input string tag);
    logic [31:0] e;
    logic        ehs, evs, evld, els, efs;
    logic [3:0]  ehc, evc;
    @(negedge clk);
    ce  = c;
    rst = r;
    if (r) begin
      hp = 0; vp = 0; m_fc = '0;
      e = {16'd0, ~HP, ~VP, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 3'b000};
    end else if (c) begin
      ehs  = (hp >= 10 && hp < 13) ? HP : ~HP;
      evs  = (vp >= 6 && vp < 8) ? VP : ~VP;
      evld = (hp < 8) && (vp < 5);
      ehc  = evld ? 4'(hp) : 4'd0;
      evc  = evld ? 4'(vp) : 4'd0;
      els  = (hp == 0);
      efs  = (hp == 0) && (vp == 0);
      if (efs) m_fc = m_fc + 16'd1;
      e = {(FC_EN ? m_fc : 16'd0), ehs, evs, evld, ehc, evc, els, efs, 3'b000};
      if (hp == HT - 1) begin
        hp = 0;
        vp = (vp == VT - 1) ? 0 : vp + 1;
      end else begin
        hp = hp + 1;
      end
    end else begin
      e = last_exp;
    end
    last_exp = e;
    q.push_back(e);
    @(posedge clk);
    #1;
    check(tag, pack_obs(), q.pop_front());
  endtask

  initial begin
    int n_hs, n_vs, n_vld, n_ls, n_fs;

    step(1'b0, 1'b1, "reset_ce0");
    step(1'b1, 1'b1, "reset_ce1");

    n_hs = 0; n_vs = 0; n_vld = 0; n_ls = 0; n_fs = 0;
    for (int i = 0; i < HT * VT; i++) begin
      step(1'b1, 1'b0, "full_rate_f1");
      if (hsync === HP) n_hs++;
      if (vsync === VP) n_vs++;
      if (valid === 1'b1) n_vld++;
      if (line_start === 1'b1) n_ls++;
      if (frame_start === 1'b1) n_fs++;
    end
    check("hsync_cycles_per_frame", 32'(n_hs), 32'(HS * VT));
    check("vsync_cycles_per_frame", 32'(n_vs), 32'(VS * HT));
    check("valid_cycles_per_frame", 32'(n_vld), 32'(HA * VA));
    check("line_starts_per_frame", 32'(n_ls), 32'(VT));
    check("frame_starts_per_frame", 32'(n_fs), 32'd1);

    for (int i = 0; i < HT * VT; i++) step(1'b1, 1'b0, "full_rate_f2");

    n_ls = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      step((i % 2) == 0, 1'b0, "half_rate");
      if (line_start === 1'b1) n_ls++;
    end
    check("line_start_clks_half_rate", 32'(n_ls), 32'(2 * VT));

    for (int i = 0; i < 150; i++) step(1'($urandom_range(0, 1)), 1'b0, "random_ce");

    for (int g = 0; g < 300 && !(hp == 5 && vp == 3); g++) step(1'b1, 1'b0, "to_mid_frame");
    step(1'b0, 1'b1, "reset_mid_frame");
    step(1'b1, 1'b0, "first_after_reset");
    check("frame_start_after_reset", {31'd0, frame_start}, 32'd1);
    check("valid_after_reset", {31'd0, valid}, 32'd1);
    step(1'b0, 1'b0, "hold_after_reset");

    for (int i = 0; i < 3 * HT * VT; i++) step(1'b1, 1'b0, "three_frames");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
